// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 inverse cipher, one round per clock.
// Optional AES_INV_CIPHER_DBG_EN adds dbg_round / dbg_round_done outputs.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_INV_CIPHER_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic         dbg_round_done
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [2047:0] ISB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE, ROUND, FINAL, DONE
  } st_t;

  st_t          st, st_n;
  logic [127:0] state, state_n;
  logic [3:0]   rnd, rnd_n;
  logic [127:0] ark;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // byte n of the block sits at [127-8n -: 8]; row n%4, column n/4
  function automatic logic [127:0] inv_shift(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] =
        ISB[2047-8*int'(s[127-8*n -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] =
          me(a[r]) ^ mb(a[(r+1)%4]) ^
          md(a[(r+2)%4]) ^ m9(a[(r+3)%4]);
    end
    return o;
  endfunction

  assign ark = inv_sub(inv_shift(state)) ^ key_in;
  assign out_data = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      st    <= st_n;
      state <= state_n;
      rnd   <= rnd_n;
    end
  end

  always_comb begin
    st_n      = st;
    state_n   = state;
    rnd_n     = rnd;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = NR_L;
    unique case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = in_data ^ key_in;
          rnd_n   = NR_L - 4'd1;
          st_n    = ROUND;
        end
      end
      ROUND: begin
        key_idx = rnd;
        state_n = inv_mix(ark);
        rnd_n   = rnd - 4'd1;
        if (rnd == 4'd1) st_n = FINAL;
      end
      FINAL: begin
        key_idx = 4'd0;
        state_n = ark;
        st_n    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

`ifdef AES_INV_CIPHER_DBG_EN
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (st == ROUND);
  end

  assign dbg_round_done = done_q;
  assign dbg_round =
    (st == IDLE || st == DONE) ? NR_L : rnd;
`endif

endmodule
